fft_dif_iter: RTL and testbench

- Parametrised iterative radix-2 decimation-in-frequency FFT/IFFT core, successor to the fixed 8-point IDIF block.
- Generalised in point count, data width and twiddle width.
- Adds a run-time forward/inverse mode, valid/ready streaming on both sides, natural-order serial output and a sticky overflow flag.
- Sits between a sample source (ADC/framer) and a downstream consumer; one frame in flight at a time.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_bfly.sv | 61 ++++++
 rtl/fft_dif_iter.sv | 143 ++++++++++++++
 tb/tb_fft_dif_iter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared helpers for the iterative DIF FFT core: index math, twiddle constants and FSM states.
package fft_pkg;

  typedef enum logic [1:0] {LOAD, COMP, OUT} fft_state_e;

  function automatic int clog2(input int unsigned v);
    int unsigned p;
    int          r;
    p = 1;
    r = 0;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Elaboration-time only: cos/sin of 2*pi*k/n scaled so that 1.0 == 2^(tw-2).
  function automatic int twiddle(input int k, input int n, input int tw, input bit sin_sel);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * k / n;
    v   = sin_sel ? $sin(ang) : $cos(ang);
    return int'(v * (2.0 ** (tw - 2)));
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 DIF butterfly with mode-dependent scaling and saturation.
module fft_bfly #(
  parameter int DW = 8,
  parameter int TW = 8
) (
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] c,
  input  logic signed [TW-1:0] s,
  input  logic                 inv,
  output logic signed [DW-1:0] y0_re,
  output logic signed [DW-1:0] y0_im,
  output logic signed [DW-1:0] y1_re,
  output logic signed [DW-1:0] y1_im,
  output logic                 sat
);

  localparam int PW = DW + TW + 2;
  localparam logic signed [PW-1:0] MAXV = PW'(2 ** (DW - 1) - 1);
  localparam logic signed [PW-1:0] MINV = PW'(-(2 ** (DW - 1)));

  logic signed [DW:0]   sr, si, dr, di;
  logic signed [PW-1:0] sum_re, sum_im, prod_re, prod_im;

  function automatic logic signed [DW-1:0] clamp(input logic signed [PW-1:0] v);
    if (v > MAXV) return {1'b0, {(DW-1){1'b1}}};
    if (v < MINV) return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction

  function automatic logic over(input logic signed [PW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  always_comb begin
    sr = (DW+1)'(a_re) + (DW+1)'(b_re);
    si = (DW+1)'(a_im) + (DW+1)'(b_im);
    dr = (DW+1)'(a_re) - (DW+1)'(b_re);
    di = (DW+1)'(a_im) - (DW+1)'(b_im);
    // Forward multiplies by C - jS, inverse by C + jS with an extra halving.
    if (!inv) begin
      sum_re  = PW'(sr);
      sum_im  = PW'(si);
      prod_re = (PW'(dr) * PW'(c) + PW'(di) * PW'(s)) >>> (TW - 2);
      prod_im = (PW'(di) * PW'(c) - PW'(dr) * PW'(s)) >>> (TW - 2);
    end else begin
      sum_re  = PW'(sr) >>> 1;
      sum_im  = PW'(si) >>> 1;
      prod_re = (PW'(dr) * PW'(c) - PW'(di) * PW'(s)) >>> (TW - 1);
      prod_im = (PW'(di) * PW'(c) + PW'(dr) * PW'(s)) >>> (TW - 1);
    end
    y0_re = clamp(sum_re);
    y0_im = clamp(sum_im);
    y1_re = clamp(prod_re);
    y1_im = clamp(prod_im);
    sat   = over(sum_re) | over(sum_im) | over(prod_re) | over(prod_im);
  end

endmodule

// File: rtl/fft_dif_iter.sv
// Iterative in-place radix-2 DIF FFT/IFFT: serial load, one butterfly per cycle, natural-order readout.
module fft_dif_iter
  import fft_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int DW = 8,
  parameter  int TW = 8,
  localparam int LG = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [LG-1:0]        out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 ovf
);

  localparam int HALF = N / 2;
  localparam int JW   = LG - 1;
  localparam int SW   = clog2(LG);

  fft_state_e state, state_nx;

  logic [LG-1:0] load_cnt;
  logic [JW-1:0] bf_j;
  logic [SW-1:0] stage;
  logic          inv_q;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];
  logic signed [TW-1:0] tw_c [HALF];
  logic signed [TW-1:0] tw_s [HALF];

  logic                 in_hs, out_hs, last_bf, bf_sat;
  logic [JW-1:0]        jmask, jm, k;
  logic [LG-1:0]        top, bot, rd_addr;
  logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;

  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam int CV = twiddle(g, N, TW, 1'b0);
    localparam int SV = twiddle(g, N, TW, 1'b1);
    assign tw_c[g] = TW'(CV);
    assign tw_s[g] = TW'(SV);
  end

  // Butterfly j of a stage: low bits of j select the offset within a group, high bits the group.
  always_comb begin
    jmask = JW'(HALF - 1) >> stage;
    jm    = bf_j & jmask;
    top   = {bf_j & ~jmask, 1'b0} | LG'(jm);
    bot   = top + LG'(jmask) + LG'(1);
    k     = jm << stage;
  end

  fft_bfly #(.DW(DW), .TW(TW)) u_bfly (
    .a_re (mem_re[top]),
    .a_im (mem_im[top]),
    .b_re (mem_re[bot]),
    .b_im (mem_im[bot]),
    .c    (tw_c[k]),
    .s    (tw_s[k]),
    .inv  (inv_q),
    .y0_re(y0_re),
    .y0_im(y0_im),
    .y1_re(y1_re),
    .y1_im(y1_im),
    .sat  (bf_sat)
  );

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign busy      = (state != LOAD);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_bf   = (stage == SW'(LG - 1)) && (bf_j == '1);
  assign out_last  = out_valid && (out_idx == '1);
  assign rd_addr   = LG'(bitrev(32'(out_idx), LG));
  assign out_re    = out_valid ? mem_re[rd_addr] : '0;
  assign out_im    = out_valid ? mem_im[rd_addr] : '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (in_hs && load_cnt == '1) state_nx = COMP;
      COMP:    if (last_bf) state_nx = OUT;
      OUT:     if (out_hs && out_idx == '1) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt <= '0;
      bf_j     <= '0;
      stage    <= '0;
      out_idx  <= '0;
      inv_q    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (in_hs) begin
        load_cnt <= load_cnt + 1'b1;
        if (load_cnt == '0) begin
          inv_q <= inv;
          ovf   <= 1'b0;
        end
      end
      if (state == COMP) begin
        bf_j <= bf_j + 1'b1;
        if (bf_j == '1) stage <= last_bf ? '0 : stage + 1'b1;
        if (bf_sat) ovf <= 1'b1;
      end
      if (out_hs) out_idx <= out_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_re[load_cnt] <= in_re;
      mem_im[load_cnt] <= in_im;
    end
    if (state == COMP) begin
      mem_re[top] <= y0_re;
      mem_im[top] <= y0_im;
      mem_re[bot] <= y1_re;
      mem_im[bot] <= y1_im;
    end
  end

endmodule

// File: tb/tb_fft_dif_iter.sv
// Scoreboard bench for fft_dif_iter: directed N=8 frames plus random frames on N=4/16/64 instances.
module tb_fft_dif_iter;

  localparam int NCFG = 4;
  localparam int CN  [NCFG] = '{8, 4, 16, 64};
  localparam int CDW [NCFG] = '{8, 12, 12, 12};
  localparam int CTW [NCFG] = '{8, 10, 10, 10};

  typedef struct {
    longint re;
    longint im;
    int     idx;
    bit     last;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  bit done_f [NCFG];

  task automatic check(input int cfg, input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL cfg%0d %s: got %0d, expected %0d", cfg, name, act, exp);
  endtask

  task automatic fail_now(input int cfg, input string name);
    total++;
    $display("FAIL cfg%0d %s", cfg, name);
  endtask

  for (genvar G = 0; G < NCFG; G++) begin : g_cfg
    localparam int N  = CN[G];
    localparam int DW = CDW[G];
    localparam int TW = CTW[G];
    localparam int LG = $clog2(N);

    logic                 rst, inv, in_valid, in_ready, out_valid, out_ready, out_last, busy, ovf;
    logic signed [DW-1:0] in_re, in_im, out_re, out_im;
    logic [LG-1:0]        out_idx;

    exp_t   q[$];
    longint xr[N];
    longint xi[N];

    fft_dif_iter #(.N(N), .DW(DW), .TW(TW)) dut (
      .clk      (clk),
      .rst      (rst),
      .inv      (inv),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_re    (in_re),
      .in_im    (in_im),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_re   (out_re),
      .out_im   (out_im),
      .out_idx  (out_idx),
      .out_last (out_last),
      .busy     (busy),
      .ovf      (ovf)
    );

    function automatic longint clampv(input longint v, inout bit ov);
      longint hi, lo;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) begin ov = 1'b1; return hi; end
      if (v < lo) begin ov = 1'b1; return lo; end
      return v;
    endfunction

    function automatic int brev(input int v);
      int r;
      r = 0;
      for (int i = 0; i < LG; i++) if ((v >> i) & 1) r |= 1 << (LG - 1 - i);
      return r;
    endfunction

    // Reference transform on xr/xi: in-place DIF with the fixed-point rules, bin k found at bitrev(k).
    task automatic push_expected(input bit inv_m);
      longint r[N];
      longint m[N];
      bit     ov;
      exp_t   e;
      ov = 1'b0;
      for (int i = 0; i < N; i++) begin r[i] = xr[i]; m[i] = xi[i]; end
      for (int s = 0; s < LG; s++) begin
        int span;
        span = N >> (s + 1);
        for (int j = 0; j < N / 2; j++) begin
          int t, b, kk;
          real ang;
          longint c, sn, sr, si, dr, di, pr, pm;
          t   = (j / span) * 2 * span + j % span;
          b   = t + span;
          kk  = (j % span) << s;
          ang = 2.0 * 3.141592653589793 * kk / N;
          c   = longint'($floor($cos(ang) * (2.0 ** (TW - 2)) + 0.5));
          sn  = longint'($floor($sin(ang) * (2.0 ** (TW - 2)) + 0.5));
          sr  = r[t] + r[b];
          si  = m[t] + m[b];
          dr  = r[t] - r[b];
          di  = m[t] - m[b];
          if (inv_m) begin
            sr = sr >>> 1;
            si = si >>> 1;
            pr = (dr * c - di * sn) >>> (TW - 1);
            pm = (di * c + dr * sn) >>> (TW - 1);
          end else begin
            pr = (dr * c + di * sn) >>> (TW - 2);
            pm = (di * c - dr * sn) >>> (TW - 2);
          end
          r[t] = clampv(sr, ov);
          m[t] = clampv(si, ov);
          r[b] = clampv(pr, ov);
          m[b] = clampv(pm, ov);
        end
      end
      for (int idx = 0; idx < N; idx++) begin
        e.re   = r[brev(idx)];
        e.im   = m[brev(idx)];
        e.idx  = idx;
        e.last = (idx == N - 1);
        e.ovf  = ov;
        q.push_back(e);
      end
    endtask

    task automatic rand_frame(input int amp);
      for (int i = 0; i < N; i++) begin
        xr[i] = longint'($urandom_range(0, 2 * amp)) - amp;
        xi[i] = longint'($urandom_range(0, 2 * amp)) - amp;
      end
    endtask

    task automatic fill(input longint re, input longint im);
      for (int i = 0; i < N; i++) begin xr[i] = re; xi[i] = im; end
    endtask

    task automatic send_frame(input bit inv_m, input bit push, input bit chk_clr, input bit chk_lat);
      int bound, cyc;
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
        inv      = inv_m;
        in_re    = DW'(xr[i]);
        in_im    = DW'(xi[i]);
        in_valid = 1'b1;
        bound    = 0;
        while (!in_ready && bound < 2000) begin
          @(negedge clk);
          bound++;
        end
        if (!in_ready) begin
          fail_now(G, "in_ready wait bound expired");
          in_valid = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
        if (i == 0 && chk_clr) check(G, "ovf clear on first sample", ovf, 0);
      end
      in_valid = 1'b0;
      if (push) push_expected(inv_m);
      if (chk_lat) begin
        cyc = 0;
        while (!out_valid && cyc < 4 * N * LG) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        check(G, "comp cycles", cyc, (N / 2) * LG);
      end
    endtask

    task automatic wait_drain();
      int cnt;
      cnt = 0;
      while ((q.size() != 0 || busy) && cnt < 20000) begin
        @(negedge clk);
        cnt++;
      end
      if (q.size() != 0 || busy) fail_now(G, "drain bound expired");
    endtask

    task automatic reset_checks();
      rst      = 1'b0;
      inv      = 1'b0;
      in_valid = 1'b0;
      in_re    = '0;
      in_im    = '0;
      repeat (2) @(negedge clk);
      check(G, "rst out_valid", out_valid, 0);
      check(G, "rst busy", busy, 0);
      check(G, "rst ovf", ovf, 0);
      check(G, "rst out_idx", out_idx, 0);
      check(G, "rst out_re", out_re, 0);
      check(G, "rst out_im", out_im, 0);
      check(G, "rst out_last", out_last, 0);
      rst = 1'b1;
      @(negedge clk);
      check(G, "in_ready after reset", in_ready, 1);
    endtask

    initial begin
      out_ready = 1'b0;
      forever begin
        @(posedge clk);
        #2 out_ready = ($urandom_range(0, 2) != 0);
      end
    end

    initial begin
      logic signed [DW-1:0] p_re, p_im;
      logic [LG-1:0]        p_idx;
      bit                   p_stall;
      exp_t                 e;
      p_stall = 1'b0;
      p_re    = '0;
      p_im    = '0;
      p_idx   = '0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          p_stall = 1'b0;
        end else begin
          check(G, "in_ready vs busy", in_ready, !busy);
          check(G, "out_last", out_last, out_valid && (out_idx == N - 1));
          if (p_stall) begin
            check(G, "stall out_valid", out_valid, 1);
            check(G, "stall out_re", out_re, p_re);
            check(G, "stall out_im", out_im, p_im);
            check(G, "stall out_idx", out_idx, p_idx);
          end
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              fail_now(G, "output with empty scoreboard");
            end else begin
              e = q.pop_front();
              check(G, "out_re", out_re, e.re);
              check(G, "out_im", out_im, e.im);
              check(G, "out_idx", out_idx, e.idx);
              check(G, "out_last at bin", out_last, e.last);
              check(G, "ovf", ovf, e.ovf);
            end
          end
          p_stall = out_valid && !out_ready;
          p_re    = out_re;
          p_im    = out_im;
          p_idx   = out_idx;
        end
      end
    end

    if (G == 0) begin : g_dir
      initial begin
        longint fr [8] = '{10, -2, -2, -2, 10, -2, -2, -2};
        longint fi [8] = '{0, 2, 0, -2, 0, 2, 0, -2};
        reset_checks();
        fill(0, 0);
        xr[0] = 8;
        send_frame(1'b1, 1'b1, 1'b0, 1'b1);
        fill(0, 0);
        xr[0] = 8;
        xr[4] = 8;
        send_frame(1'b1, 1'b1, 1'b0, 1'b1);
        fill(1, 0);
        send_frame(1'b0, 1'b1, 1'b0, 1'b1);
        fill(127, 127);
        send_frame(1'b0, 1'b1, 1'b0, 1'b1);
        rand_frame(6);
        send_frame(1'b0, 1'b1, 1'b1, 1'b1);
        wait_drain();
        // Abort a saturating frame five butterflies into the compute phase.
        fill(127, 127);
        send_frame(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check(G, "ovf set before abort", ovf, 1);
        rst = 1'b0;
        #1;
        check(G, "abort out_valid", out_valid, 0);
        check(G, "abort busy", busy, 0);
        check(G, "abort ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin xr[i] = fr[i]; xi[i] = fi[i]; end
        send_frame(1'b1, 1'b1, 1'b0, 1'b1);
        for (int f = 0; f < 4; f++) begin
          rand_frame(60);
          send_frame(f[0], 1'b1, 1'b0, 1'b1);
        end
        wait_drain();
        done_f[G] = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        reset_checks();
        for (int f = 0; f < 6; f++) begin
          rand_frame(f < 3 ? (2 ** (DW - 1)) / N : 2 ** (DW - 1) - 1);
          send_frame(f[0], 1'b1, 1'b0, 1'b1);
        end
        wait_drain();
        done_f[G] = 1'b1;
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 60000 && !all_done; c++) begin
      @(posedge clk);
      all_done = 1'b1;
      for (int g = 0; g < NCFG; g++) if (!done_f[g]) all_done = 1'b0;
    end
    if (!all_done) fail_now(-1, "run time limit expired");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
